// File: rtl/rvmc_pkg.sv
// rvmc_pkg: shared types and encodings for the multicycle RISC-V control unit.
//   state_t      - FSM state encoding (exported on state_o for debug)
//   OP_*         - opcode values recognised by the decoder
//   ALU_*        - ALUControl encodings
//   aluop_t      - coarse ALU operation class chosen per state
//   RES_*/SRCA_*/SRCB_*/IMM_* - datapath select encodings
//   imm_src()    - immediate format selection from the opcode
package rvmc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BR:   imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/rvmc_aludec.sv
// rvmc_aludec: combinational ALU decoder.
//   alu_op      in  coarse operation class from the FSM
//   funct3      in  Instr[14:12]
//   funct7b5    in  Instr[30]
//   op5         in  Instr[5] (distinguishes R-type from I-type)
//   alu_control out ALUControl encoding
//   legal       out funct3/funct7 decode is supported; reflects the R/I
//                   decode regardless of alu_op so DECODE can screen it
//                   while the ALU itself is still doing an add
// Parameter EXT_ALU enables xor/sll/srl.
module rvmc_aludec
    import rvmc_pkg::*;
#(
    parameter int unsigned EXT_ALU = 0
) (
    input  aluop_t      alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output logic [2:0]  alu_control,
    output logic        legal
);

    logic [2:0] funct_ctrl;
    logic       ext_en;

    assign ext_en = (EXT_ALU != 0);

    always_comb begin
        funct_ctrl = ALU_ADD;
        legal      = 1'b0;
        case (funct3)
            3'b000: begin
                legal      = 1'b1;
                // I-type never subtracts: funct7b5 there is immediate bits
                funct_ctrl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
            end
            3'b010: begin legal = 1'b1;   funct_ctrl = ALU_SLT; end
            3'b110: begin legal = 1'b1;   funct_ctrl = ALU_OR;  end
            3'b111: begin legal = 1'b1;   funct_ctrl = ALU_AND; end
            3'b100: begin legal = ext_en; funct_ctrl = ALU_XOR; end
            3'b001: begin legal = ext_en; funct_ctrl = ALU_SLL; end
            3'b101: begin legal = ext_en; funct_ctrl = ALU_SRL; end
            default: begin legal = 1'b0;  funct_ctrl = ALU_ADD; end
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = legal ? funct_ctrl : ALU_ADD;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rvmc_controller.sv
// rvmc_controller: multicycle Moore control FSM for a RISC-V core with a
// shared instruction/data memory and a ready-handshaked memory port.
//   Inputs : clk, reset (sync, active-high), op, funct3, funct7b5, Zero,
//            mem_ready
//   Outputs: PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
//            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, fault, state_o
// Parameters: EXT_ALU (xor/sll/srl decode), MEM_TIMEOUT (wait-state limit,
// 0 = none).
// Macro RVMC_BNE_EN: accept bne (branch funct3 001, taken on !Zero).
module rvmc_controller
    import rvmc_pkg::*;
#(
    parameter int unsigned EXT_ALU     = 0,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        fault,
    output logic [3:0]  state_o
);

    localparam int unsigned WAIT_W =
        (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    aluop_t              alu_op;
    logic                funct_legal;
    logic                branch_legal;
    logic                taken;
    logic                mem_wait;
    logic                timeout;

    logic                pc_update;
    logic                branch;
    logic                ir_write_raw;
    logic                mem_read_raw;
    logic                mem_write_raw;
    logic                reg_write_raw;

    rvmc_aludec #(
        .EXT_ALU (EXT_ALU)
    ) u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl),
        .legal       (funct_legal)
    );

    always_comb begin
`ifdef RVMC_BNE_EN
        branch_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        taken        = (funct3 == 3'b001) ? ~Zero : Zero;
`else
        branch_legal = (funct3 == 3'b000);
        taken        = Zero;
`endif
    end

    // A wait cycle is any cycle in a memory state without a completed access.
    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE)) && !mem_ready;
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == WAIT_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = funct_legal  ? S_EXECUTER : S_FAULT;
                    OP_I:         state_d = funct_legal  ? S_EXECUTEI : S_FAULT;
                    OP_BR:        state_d = branch_legal ? S_BRANCH   : S_FAULT;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase
    end

    // Saturating wait counter, cleared whenever the state changes.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (mem_wait && (wait_q != '1))
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_WD;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                mem_read_raw = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_WD;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_WD;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked during reset so an in-flight access is dropped
    // in the same cycle reset is raised.
    assign PCWrite  = ~reset & (pc_update | (branch & taken));
    assign IRWrite  = ~reset & ir_write_raw;
    assign MemRead  = ~reset & mem_read_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign RegWrite = ~reset & reg_write_raw;

    assign ImmSrc  = imm_src(op);
    assign fault   = (state_q == S_FAULT);
    assign state_o = state_q;

endmodule

// File: tb/tb_rvmc_controller.sv
// tb_rvmc_controller: directed bench for rvmc_controller.
// Two instances share the stimulus: dut_a (EXT_ALU=0, MEM_TIMEOUT=4) and
// dut_b (EXT_ALU=1, MEM_TIMEOUT=0). Honours RVMC_BNE_EN for bne checks.
`timescale 1ns/1ps
module tb_rvmc_controller;
  import rvmc_pkg::*;

  int n_total = 0;
  int n_bad   = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       a_PCWrite, a_AdrSrc, a_MemRead, a_MemWrite, a_IRWrite, a_RegWrite, a_fault;
  logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc;
  logic [2:0] a_ALUControl;
  logic [3:0] a_state;

  logic       b_PCWrite, b_AdrSrc, b_MemRead, b_MemWrite, b_IRWrite, b_RegWrite, b_fault;
  logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
  logic [2:0] b_ALUControl;
  logic [3:0] b_state;

  always #5 clk = ~clk;

  rvmc_controller #(.EXT_ALU(0), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(a_PCWrite), .AdrSrc(a_AdrSrc), .MemRead(a_MemRead),
    .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegWrite(a_RegWrite),
    .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
    .ImmSrc(a_ImmSrc), .ALUControl(a_ALUControl), .fault(a_fault),
    .state_o(a_state)
  );

  rvmc_controller #(.EXT_ALU(1), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .MemRead(b_MemRead),
    .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite),
    .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ImmSrc(b_ImmSrc), .ALUControl(b_ALUControl), .fault(b_fault),
    .state_o(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen between edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; op = OP_LW; funct3 = 3'b010;
    funct7b5 = 1'b0; Zero = 1'b0;

    // reset state, enables masked while reset is high
    step(); #1;
    chk("rst_state", a_state, S_FETCH);
    chk("rst_memread", a_MemRead, 1'b0);
    chk("rst_pcwrite", a_PCWrite, 1'b0);
    chk("rst_irwrite", a_IRWrite, 1'b0);
    chk("rst_fault", a_fault, 1'b0);

    // lw, memory always ready
    reset = 1'b0; mem_ready = 1'b1; #1;
    chk("lw_fetch_memread", a_MemRead, 1'b1);
    chk("lw_fetch_irwrite", a_IRWrite, 1'b1);
    chk("lw_fetch_pcwrite", a_PCWrite, 1'b1);
    chk("lw_fetch_srcb", a_ALUSrcB, 2'b10);
    chk("lw_fetch_ressrc", a_ResultSrc, 2'b10);
    chk("lw_fetch_adrsrc", a_AdrSrc, 1'b0);
    step(); #1;
    chk("lw_decode_state", a_state, S_DECODE);
    chk("lw_decode_srca", a_ALUSrcA, 2'b01);
    chk("lw_decode_srcb", a_ALUSrcB, 2'b01);
    chk("lw_decode_irwrite", a_IRWrite, 1'b0);
    chk("lw_decode_pcwrite", a_PCWrite, 1'b0);
    chk("lw_immsrc", a_ImmSrc, 2'b00);
    step(); #1;
    chk("lw_memadr_state", a_state, S_MEMADR);
    chk("lw_memadr_srca", a_ALUSrcA, 2'b10);
    step(); #1;
    chk("lw_memread_state", a_state, S_MEMREAD);
    chk("lw_memread_adrsrc", a_AdrSrc, 1'b1);
    chk("lw_memread_memread", a_MemRead, 1'b1);
    chk("lw_memread_regwrite", a_RegWrite, 1'b0);
    step(); #1;
    chk("lw_memwb_state", a_state, S_MEMWB);
    chk("lw_memwb_regwrite", a_RegWrite, 1'b1);
    chk("lw_memwb_ressrc", a_ResultSrc, 2'b01);
    step(); #1;
    chk("lw_back_fetch", a_state, S_FETCH);
    chk("lw_fetch_regwrite", a_RegWrite, 1'b0);

    // fetch stalled three cycles, then beq
    mem_ready = 1'b0; op = OP_BR; funct3 = 3'b000;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (a_state !== S_FETCH) begin
        n_bad++;
        $error("FAIL stall_state observed=%0h expected=%0h", a_state, S_FETCH);
      end
      n_total++;
      if (a_IRWrite !== 1'b0) begin
        n_bad++;
        $error("FAIL stall_irwrite observed=%0h expected=0", a_IRWrite);
      end
      n_total++;
      if (a_PCWrite !== 1'b0) begin
        n_bad++;
        $error("FAIL stall_pcwrite observed=%0h expected=0", a_PCWrite);
      end
      step();
    end
    mem_ready = 1'b1; #1;
    chk("stall_release_irwrite", a_IRWrite, 1'b1);
    chk("stall_release_pcwrite", a_PCWrite, 1'b1);
    step(); #1;
    chk("beq_decode", a_state, S_DECODE);
    chk("beq_immsrc", a_ImmSrc, 2'b10);
    step();
    Zero = 1'b1; #1;
    chk("beq_state", a_state, S_BRANCH);
    chk("beq_alu_sub", a_ALUControl, 3'b001);
    chk("beq_taken_pcwrite", a_PCWrite, 1'b1);
    Zero = 1'b0; #1;
    chk("beq_not_taken_pcwrite", a_PCWrite, 1'b0);
    step(); #1;
    chk("beq_back_fetch", a_state, S_FETCH);

    // bne
    funct3 = 3'b001;
    step(); step(); #1;
`ifdef RVMC_BNE_EN
    chk("bne_state", a_state, S_BRANCH);
    chk("bne_taken_pcwrite", a_PCWrite, 1'b1);
    Zero = 1'b1; #1;
    chk("bne_not_taken_pcwrite", a_PCWrite, 1'b0);
`else
    chk("bne_state", a_state, S_FAULT);
    chk("bne_fault", a_fault, 1'b1);
`endif
    Zero = 1'b0;
    reset_pulse();

    // R-type sub
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step(); #1;
    chk("sub_state", a_state, S_EXECUTER);
    chk("sub_alu_a", a_ALUControl, 3'b001);
    chk("sub_alu_b", b_ALUControl, 3'b001);
    chk("sub_srca", a_ALUSrcA, 2'b10);
    chk("sub_srcb", a_ALUSrcB, 2'b00);
    step(); #1;
    chk("sub_aluwb_state", a_state, S_ALUWB);
    chk("sub_aluwb_regwrite", a_RegWrite, 1'b1);
    chk("sub_aluwb_ressrc", a_ResultSrc, 2'b00);
    step();

    // I-type funct3 000 with bit 30 set is still an add
    op = OP_I;
    step(); step(); #1;
    chk("addi_state", a_state, S_EXECUTEI);
    chk("addi_alu", a_ALUControl, 3'b000);
    chk("addi_srcb", a_ALUSrcB, 2'b01);
    step(); step();

    // ori
    funct3 = 3'b110; funct7b5 = 1'b0;
    step(); step(); #1;
    chk("ori_alu", a_ALUControl, 3'b011);
    step(); step();

    // xor: illegal without EXT_ALU, decoded with it
    op = OP_R; funct3 = 3'b100;
    step(); step(); #1;
    chk("xor_a_state", a_state, S_FAULT);
    chk("xor_a_fault", a_fault, 1'b1);
    chk("xor_a_regwrite", a_RegWrite, 1'b0);
    chk("xor_a_memread", a_MemRead, 1'b0);
    chk("xor_a_pcwrite", a_PCWrite, 1'b0);
    chk("xor_b_state", b_state, S_EXECUTER);
    chk("xor_b_alu", b_ALUControl, 3'b100);
    step(); #1;
    chk("xor_a_sticky", a_state, S_FAULT);
    chk("xor_b_aluwb", b_state, S_ALUWB);
    reset_pulse();

    // jal
    op = OP_JAL;
    step(); #1;
    chk("jal_immsrc", a_ImmSrc, 2'b11);
    step(); #1;
    chk("jal_state", a_state, S_JAL);
    chk("jal_pcwrite", a_PCWrite, 1'b1);
    chk("jal_srca", a_ALUSrcA, 2'b01);
    chk("jal_srcb", a_ALUSrcB, 2'b10);
    step(); #1;
    chk("jal_aluwb", a_state, S_ALUWB);
    step();

    // sw with memory never ready: timeout after 4 wait cycles
    op = OP_SW; funct3 = 3'b010;
    step(); #1;
    chk("sw_immsrc", a_ImmSrc, 2'b01);
    step(); mem_ready = 1'b0;
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (a_state !== S_MEMWRITE) begin
        n_bad++;
        $error("FAIL sw_wait_state observed=%0h expected=%0h", a_state, S_MEMWRITE);
      end
      n_total++;
      if (a_MemWrite !== 1'b1) begin
        n_bad++;
        $error("FAIL sw_wait_memwrite observed=%0h expected=1", a_MemWrite);
      end
      n_total++;
      if (a_AdrSrc !== 1'b1) begin
        n_bad++;
        $error("FAIL sw_wait_adrsrc observed=%0h expected=1", a_AdrSrc);
      end
      step();
    end
    #1;
    chk("sw_timeout_state", a_state, S_FAULT);
    chk("sw_timeout_memwrite", a_MemWrite, 1'b0);
    chk("sw_timeout_fault", a_fault, 1'b1);
    chk("sw_b_still_waiting", b_state, S_MEMWRITE);
    chk("sw_b_memwrite", b_MemWrite, 1'b1);
    step(); #1;
    chk("sw_fault_sticky", a_state, S_FAULT);

    // reset during a pending write
    reset = 1'b1; #1;
    chk("rst_mid_b_memwrite", b_MemWrite, 1'b0);
    chk("rst_mid_a_memwrite", a_MemWrite, 1'b0);
    step(); reset = 1'b0; #1;
    chk("rst_mid_b_fetch", b_state, S_FETCH);
    chk("rst_mid_a_fetch", a_state, S_FETCH);
    chk("rst_mid_a_fault", a_fault, 1'b0);

    // unknown opcode
    mem_ready = 1'b1; op = 7'b1111111;
    step(); step(); #1;
    chk("badop_a_state", a_state, S_FAULT);
    chk("badop_b_state", b_state, S_FAULT);
    chk("badop_b_fault", b_fault, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
